// File: rtl/chunked_addsub_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract unit.
package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth  = 16;
    localparam int unsigned DefaultChunk  = 4;

    function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int unsigned calc_idx_w(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    localparam int unsigned NCHUNK = calc_nchunk(DefaultWidth, DefaultChunk);
    localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);

endpackage

// File: rtl/chunked_addsub_adder_slice.sv
// CHUNK-bit ripple-carry slice; exports the carry into its top bit for overflow detection.
module adder_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice reused across NCHUNK clocks per operation.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NChunk = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IdxW   = calc_idx_w(NChunk);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("chunked_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] slice_x, slice_y, slice_s;
    logic             slice_co, slice_c_msb;

    assign slice_x = a_q[idx_q*CHUNK +: CHUNK];
    assign slice_y = b_q[idx_q*CHUNK +: CHUNK];

    adder_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .x        (slice_x),
        .y        (slice_y),
        .ci       (carry_q),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // Subtraction as a + ~b + ~borrow keeps one adder for both operations.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[idx_q*CHUNK +: CHUNK] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_co;
                    ovf_d   = slice_co ^ slice_c_msb;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed self-checking bench for chunked_addsub with the default 16/4 configuration.
module tb_chunked_addsub;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chunked_addsub #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and check latency, busy span, result and one-cycle done pulse.
    task automatic run_op(input string tag, input logic s, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci, input logic [15:0] es,
                          input logic ec, input logic eo);
        int cycles;
        int busy_cnt;
        bit got;
        cycles   = 0;
        busy_cnt = 0;
        got      = 1'b0;
        a        = av;
        b        = bv;
        sub      = s;
        cin      = ci;
        start    = 1'b1;
        while (!got && cycles <= 20) begin
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cnt++;
                cycles++;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, cycles, 32'd4);
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_sum_held"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int cycles;
        int gap;
        int done_cnt;

        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_00ff_1", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_5_7", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_10_1_bin", 1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0);

        // start held and operands changed while running must not disturb the operation
        a     = 16'h1234;
        b     = 16'h0F0F;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        sub = 1'b1;
        cin = 1'b1;
        @(negedge clk);
        chk("run_busy_mid", 32'(busy), 32'd1);
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk("run_ign_latency", cycles, 32'd2);
        chk("run_ign_sum", 32'(sum), 32'h2143);
        chk("run_ign_cout", 32'(cout), 32'd0);
        chk("run_ign_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        chk("run_ign_no_restart", 32'(busy), 32'd0);
        chk("run_ign_done_low", 32'(done), 32'd0);

        // back-to-back: start asserted while done is high
        a      = 16'h1000;
        b      = 16'h0234;
        sub    = 1'b0;
        cin    = 1'b0;
        start  = 1'b1;
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        chk("b2b_first_sum", 32'(sum), 32'h1234);
        a     = 16'h0003;
        b     = 16'h0004;
        sub   = 1'b1;
        start = 1'b1;
        gap   = 0;
        while (gap < 20) begin
            @(negedge clk);
            start = 1'b0;
            gap++;
            if (done) break;
        end
        chk("b2b_gap", gap, 32'd5);
        chk("b2b_second_sum", 32'(sum), 32'hFFFF);
        chk("b2b_second_cout", 32'(cout), 32'd0);
        chk("b2b_second_ovf", 32'(overflow), 32'd0);
        @(negedge clk);

        // reset during the second RUN cycle
        a     = 16'h1111;
        b     = 16'h2222;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        reset    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("mid_rst_no_done", done_cnt, 32'd0);
        run_op("post_rst", 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
